// File: rtl/duck_motion_ctl_pkg.sv
// Shared definitions for the duck motion sequencer: states, sprite select codes
// and default screen/sprite constants reused by game logic and the ROM address mux.
package duck_motion_ctl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFly,
        StHit,
        StFall,
        StEscape
    } duck_state_e;

    localparam logic [1:0] SEL_FLY  = 2'd0;
    localparam logic [1:0] SEL_HIT  = 2'd1;
    localparam logic [1:0] SEL_FALL = 2'd2;

    localparam int unsigned DEF_SCREEN_W   = 1024;
    localparam int unsigned DEF_GROUND_Y   = 600;
    localparam int unsigned DEF_SPRITE_W   = 48;
    localparam int unsigned DEF_SPRITE_H   = 64;
    localparam int unsigned DEF_SPEED_X    = 3;
    localparam int unsigned DEF_SPEED_Y    = 2;
    localparam int unsigned DEF_FALL_SPEED = 4;
    localparam int unsigned DEF_HIT_FRAMES = 30;
    localparam int unsigned DEF_FLY_FRAMES = 300;
    localparam int unsigned DEF_ANIM_DIV   = 6;
    localparam int unsigned DEF_NUM_ANIM   = 3;

endpackage

// File: rtl/duck_motion_ctl_if.sv
// Game-logic side of the duck sequencer: launch/hit controls in, sprite
// position, selection and event pulses out.
interface duck_motion_ctl_if;

    logic        start;
    logic [10:0] start_x;
    logic [1:0]  start_dir;
    logic        shot_hit;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic [1:0]  sprite_sel;
    logic [1:0]  anim_frame;
    logic        visible;
    logic        duck_hit;
    logic        duck_landed;
    logic        duck_escaped;
    logic        busy;

    modport master (
        output start, start_x, start_dir, shot_hit,
        input  xpos, ypos, sprite_sel, anim_frame, visible,
        input  duck_hit, duck_landed, duck_escaped, busy
    );

    modport slave (
        input  start, start_x, start_dir, shot_hit,
        output xpos, ypos, sprite_sel, anim_frame, visible,
        output duck_hit, duck_landed, duck_escaped, busy
    );

endinterface

// File: rtl/duck_motion_ctl_frame_tick.sv
// Two-flop synchroniser plus rising-edge detector on vsync; emits a registered
// one-cycle frame tick three clocks after the vsync rising edge.
module duck_motion_ctl_frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic tick
);

    logic [2:0] sync_q;
    logic       tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], vsync_in};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/duck_motion_ctl.sv
// Per-frame duck sprite sequencer: flight with wall bounce, hit freeze, fall to
// ground and escape off the top, advancing once per vsync tick.
module duck_motion_ctl
    import duck_motion_ctl_pkg::*;
#(
    parameter int unsigned SCREEN_W   = DEF_SCREEN_W,
    parameter int unsigned GROUND_Y   = DEF_GROUND_Y,
    parameter int unsigned SPRITE_W   = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H   = DEF_SPRITE_H,
    parameter int unsigned SPEED_X    = DEF_SPEED_X,
    parameter int unsigned SPEED_Y    = DEF_SPEED_Y,
    parameter int unsigned FALL_SPEED = DEF_FALL_SPEED,
    parameter int unsigned HIT_FRAMES = DEF_HIT_FRAMES,
    parameter int unsigned FLY_FRAMES = DEF_FLY_FRAMES,
    parameter int unsigned ANIM_DIV   = DEF_ANIM_DIV,
    parameter int unsigned NUM_ANIM   = DEF_NUM_ANIM
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vsync_in,
    duck_motion_ctl_if.slave bus
);

    localparam logic [10:0]        X_MAX     = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0]        Y_MAX     = 11'(GROUND_Y - SPRITE_H);
    localparam logic signed [11:0] X_MAX_S   = 12'(SCREEN_W - SPRITE_W);
    localparam logic signed [11:0] Y_MAX_S   = 12'(GROUND_Y - SPRITE_H);
    localparam logic signed [11:0] SPD_X_S   = 12'(SPEED_X);
    localparam logic signed [11:0] SPD_Y_S   = 12'(SPEED_Y);
    localparam logic signed [11:0] FALL_S    = 12'(FALL_SPEED);
    localparam logic [15:0]        FLY_LAST  = 16'(FLY_FRAMES - 1);
    localparam logic [15:0]        HIT_LAST  = 16'(HIT_FRAMES - 1);
    localparam logic [7:0]         ANIM_LAST = 8'(ANIM_DIV - 1);
    localparam logic [1:0]         FRM_LAST  = 2'(NUM_ANIM - 1);

    duck_state_e state_q;
    logic [10:0] xpos_q, ypos_q;
    logic        dir_right_q, dir_down_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  anim_cnt_q;
    logic [1:0]  anim_frame_q, sprite_sel_q;
    logic        visible_q, busy_q, hit_q, landed_q, escaped_q;
    logic        tick;

    duck_motion_ctl_frame_tick u_frame_tick (
        .clk      (pclk),
        .rst_n    (rst_n),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    // Signed 12-bit step so moving left/up past zero goes negative instead of wrapping.
    logic signed [11:0] x_cur, y_cur, x_step, y_step, y_fall;
    logic [10:0]        x_next, y_next;
    logic               dir_right_next, dir_down_next, land_now, esc_done;

    always_comb begin
        x_cur          = $signed({1'b0, xpos_q});
        y_cur          = $signed({1'b0, ypos_q});
        x_step         = dir_right_q ? x_cur + SPD_X_S : x_cur - SPD_X_S;
        y_step         = dir_down_q  ? y_cur + SPD_Y_S : y_cur - SPD_Y_S;
        y_fall         = y_cur + FALL_S;
        x_next         = x_step[10:0];
        y_next         = y_step[10:0];
        dir_right_next = dir_right_q;
        dir_down_next  = dir_down_q;
        if (x_step < 12'sd0) begin
            x_next         = '0;
            dir_right_next = ~dir_right_q;
        end else if (x_step > X_MAX_S) begin
            x_next         = X_MAX;
            dir_right_next = ~dir_right_q;
        end
        if (y_step < 12'sd0) begin
            y_next        = '0;
            dir_down_next = ~dir_down_q;
        end else if (y_step > Y_MAX_S) begin
            y_next        = Y_MAX;
            dir_down_next = ~dir_down_q;
        end
        land_now = (y_fall >= Y_MAX_S);
        esc_done = (ypos_q < 11'(SPEED_Y));
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            xpos_q       <= '0;
            ypos_q       <= '0;
            dir_right_q  <= 1'b0;
            dir_down_q   <= 1'b0;
            frame_cnt_q  <= '0;
            anim_cnt_q   <= '0;
            anim_frame_q <= '0;
            sprite_sel_q <= SEL_FLY;
            visible_q    <= 1'b0;
            busy_q       <= 1'b0;
            hit_q        <= 1'b0;
            landed_q     <= 1'b0;
            escaped_q    <= 1'b0;
        end else begin
            hit_q     <= 1'b0;
            landed_q  <= 1'b0;
            escaped_q <= 1'b0;
            unique case (state_q)
                StIdle: if (bus.start) begin
                    state_q      <= StFly;
                    xpos_q       <= (bus.start_x > X_MAX) ? X_MAX : bus.start_x;
                    ypos_q       <= Y_MAX;
                    dir_right_q  <= bus.start_dir[0];
                    dir_down_q   <= bus.start_dir[1];
                    frame_cnt_q  <= '0;
                    anim_cnt_q   <= '0;
                    anim_frame_q <= '0;
                    sprite_sel_q <= SEL_FLY;
                    visible_q    <= 1'b1;
                    busy_q       <= 1'b1;
                end
                // A hit coinciding with a tick takes priority and suppresses the move.
                StFly: if (bus.shot_hit) begin
                    state_q      <= StHit;
                    sprite_sel_q <= SEL_HIT;
                    hit_q        <= 1'b1;
                    frame_cnt_q  <= '0;
                end else if (tick) begin
                    xpos_q      <= x_next;
                    ypos_q      <= y_next;
                    dir_right_q <= dir_right_next;
                    dir_down_q  <= dir_down_next;
                    if (anim_cnt_q == ANIM_LAST) begin
                        anim_cnt_q   <= '0;
                        anim_frame_q <= (anim_frame_q == FRM_LAST) ? 2'd0 : anim_frame_q + 2'd1;
                    end else begin
                        anim_cnt_q <= anim_cnt_q + 8'd1;
                    end
                    if (frame_cnt_q == FLY_LAST) begin
                        state_q     <= StEscape;
                        frame_cnt_q <= '0;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                StHit: if (tick) begin
                    if (frame_cnt_q == HIT_LAST) begin
                        state_q      <= StFall;
                        sprite_sel_q <= SEL_FALL;
                        frame_cnt_q  <= '0;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end
                end
                StFall: if (tick) begin
                    if (land_now) begin
                        ypos_q       <= Y_MAX;
                        landed_q     <= 1'b1;
                        state_q      <= StIdle;
                        sprite_sel_q <= SEL_FLY;
                        visible_q    <= 1'b0;
                        busy_q       <= 1'b0;
                    end else begin
                        ypos_q <= y_fall[10:0];
                    end
                end
                StEscape: if (tick) begin
                    if (esc_done) begin
                        escaped_q <= 1'b1;
                        state_q   <= StIdle;
                        visible_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        ypos_q <= ypos_q - 11'(SPEED_Y);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.xpos         = xpos_q;
    assign bus.ypos         = ypos_q;
    assign bus.sprite_sel   = sprite_sel_q;
    assign bus.anim_frame   = anim_frame_q;
    assign bus.visible      = visible_q;
    assign bus.busy         = busy_q;
    assign bus.duck_hit     = hit_q;
    assign bus.duck_landed  = landed_q;
    assign bus.duck_escaped = escaped_q;

endmodule
